wdt_reset_sequencer: RTL and testbench



---
 rtl/wdt_seq_pkg.sv | 39 +++
 rtl/wdt_cycle_timer.sv | 29 ++
 rtl/wdt_reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_wdt_reset_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wdt_seq_pkg.sv
// Shared definitions for the watchdog reset sequencer: state encoding,
// default timing parameters and the expiry counter width.
package wdt_seq_pkg;

    localparam int STATE_W   = 3;
    localparam int EXP_CNT_W = 4;

    localparam int DEF_WARN_CYCLES    = 4;
    localparam int DEF_RST_CYCLES     = 8;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int DEF_MAX_RESETS     = 3;
    localparam int DEF_CNT_W          = 16;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WARN    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RESET   = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLDOFF = 3'd3;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = ST_IDLE,
        WARN    = ST_WARN,
        RESET   = ST_RESET,
        HOLDOFF = ST_HOLDOFF,
        LOCKOUT = ST_LOCKOUT
    } seq_state_t;

    // Saturating increment of the expiry counter at the given ceiling.
    function automatic logic [EXP_CNT_W-1:0] sat_inc(
        input logic [EXP_CNT_W-1:0] value,
        input logic [EXP_CNT_W-1:0] ceiling
    );
        if (value >= ceiling) begin
            return ceiling;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/wdt_cycle_timer.sv
// Loadable down-counter used to time each phase of the reset sequence.
// done is high whenever the count has reached zero.
module wdt_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // A load takes priority over counting; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/wdt_reset_sequencer.sv
// Turns a watchdog expiry into alarm -> timed system reset -> hold-off,
// counting issued resets and locking out after MAX_RESETS of them.
module wdt_reset_sequencer
    import wdt_seq_pkg::*;
#(
    parameter int WARN_CYCLES    = DEF_WARN_CYCLES,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int MAX_RESETS     = DEF_MAX_RESETS,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 watchdog_expired,
    input  logic                 clr_count,
    output logic                 alarm,
    output logic                 sys_rst_n,
    output logic                 lockout,
    output logic [EXP_CNT_W-1:0] expiry_count,
    output logic [STATE_W-1:0]   state_o
);

    localparam logic [CNT_W-1:0]     WARN_LOAD    = CNT_W'(WARN_CYCLES - 1);
    localparam logic [CNT_W-1:0]     RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [EXP_CNT_W-1:0] MAX_CNT      = EXP_CNT_W'(MAX_RESETS);

    seq_state_t       state;
    logic             trigger;
    logic             warn_abort;
    logic             at_max;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_done;

    assign trigger    = ena && watchdog_expired;
    assign warn_abort = !trigger;
    assign at_max     = (expiry_count == MAX_CNT);

    // Timer reload decisions mirror the FSM transitions below.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    tmr_load = 1'b1;
                    tmr_val  = WARN_LOAD;
                end
            end
            WARN: begin
                if (!warn_abort && tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = RST_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESET: begin
                if (tmr_done && !at_max) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLDOFF_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            HOLDOFF: begin
                tmr_en = 1'b1;
            end
            default: begin
                tmr_en = 1'b0;
            end
        endcase
    end

    wdt_cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alarm        <= 1'b0;
            sys_rst_n    <= 1'b1;
            lockout      <= 1'b0;
            expiry_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= WARN;
                        alarm <= 1'b1;
                    end
                end
                WARN: begin
                    if (warn_abort) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end else if (tmr_done) begin
                        state        <= RESET;
                        alarm        <= 1'b0;
                        sys_rst_n    <= 1'b0;
                        expiry_count <= sat_inc(expiry_count, MAX_CNT);
                    end
                end
                RESET: begin
                    if (tmr_done) begin
                        if (at_max) begin
                            state   <= LOCKOUT;
                            lockout <= 1'b1;
                        end else begin
                            state     <= HOLDOFF;
                            sys_rst_n <= 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (tmr_done) begin
                        state <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (clr_count) begin
                        state     <= IDLE;
                        sys_rst_n <= 1'b1;
                        lockout   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    alarm     <= 1'b0;
                    sys_rst_n <= 1'b1;
                    lockout   <= 1'b0;
                end
            endcase
            // Clearing overrides any increment taken on this same edge.
            if (clr_count) begin
                expiry_count <= '0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Randomised scoreboard bench for wdt_reset_sequencer against an
// elapsed-time reference model of the alarm / reset / hold-off sequence.
module tb_wdt_reset_sequencer;

    localparam int W   = 4;
    localparam int R   = 8;
    localparam int H   = 16;
    localparam int MAX = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       watchdog_expired;
    logic       clr_count;
    logic       alarm;
    logic       sys_rst_n;
    logic       lockout;
    logic [3:0] expiry_count;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    // Expected vector: {state, lockout, sys_rst_n, alarm, expiry_count}
    logic [9:0] exp_q[$];

    // Reference model: elapsed cycles since the triggering edge.
    bit m_busy;
    int m_t;
    int m_cnt;
    bit m_locked;

    wdt_reset_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ena              (ena),
        .watchdog_expired (watchdog_expired),
        .clr_count        (clr_count),
        .alarm            (alarm),
        .sys_rst_n        (sys_rst_n),
        .lockout          (lockout),
        .expiry_count     (expiry_count),
        .state_o          (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] dut_vec();
        return {state_o, lockout, sys_rst_n, alarm, expiry_count};
    endfunction

    function automatic logic [9:0] model_vec();
        logic [3:0] c;
        c = 4'(m_cnt);
        if (m_locked)        return {3'd4, 1'b1, 1'b0, 1'b0, c};
        else if (!m_busy)    return {3'd0, 1'b0, 1'b1, 1'b0, c};
        else if (m_t < W)    return {3'd1, 1'b0, 1'b1, 1'b1, c};
        else if (m_t < W + R) return {3'd2, 1'b0, 1'b0, 1'b0, c};
        else                 return {3'd3, 1'b0, 1'b1, 1'b0, c};
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_t      = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit e, input bit x, input bit c);
        bit was_max;
        was_max = (m_cnt == MAX);
        if (m_locked) begin
            if (c) m_locked = 1'b0;
        end else if (!m_busy) begin
            if (e && x) begin
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else if (m_t < W) begin
            if (!(e && x)) begin
                m_busy = 1'b0;
            end else begin
                m_t++;
                if (m_t == W && m_cnt < MAX) m_cnt++;
            end
        end else begin
            m_t++;
            if (m_t == W + R && was_max) begin
                m_busy   = 1'b0;
                m_locked = 1'b1;
            end else if (m_t == W + R + H) begin
                m_busy = 1'b0;
            end
        end
        if (c) m_cnt = 0;
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got state=%0d lock=%b srst_n=%b alarm=%b cnt=%0d, want state=%0d lock=%b srst_n=%b alarm=%b cnt=%0d",
                     name, got[9:7], got[6], got[5], got[4], got[3:0],
                     want[9:7], want[6], want[5], want[4], want[3:0]);
        end
    endtask

    task automatic step(input bit e, input bit x, input bit c);
        @(negedge clk);
        ena              = e;
        watchdog_expired = x;
        clr_count        = c;
        model_edge(e, x, c);
        exp_q.push_back(model_vec());
    endtask

    // Monitor: one expected entry per rising edge, checked shortly after it.
    initial begin
        logic [9:0] want;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("outputs", dut_vec(), want);
            end
        end
    end

    initial begin
        int guard;
        rst_n            = 1'b0;
        ena              = 1'b0;
        watchdog_expired = 1'b0;
        clr_count        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 4'd0});
        rst_n = 1'b1;

        // Nominal expiry, released during hold-off.
        for (int i = 0; i < 28; i++) step(1, 1, 0);
        repeat (5) step(1, 0, 0);

        // Kick during warning.
        repeat (2) step(1, 1, 0);
        repeat (6) step(1, 0, 0);

        // Escalation into lockout, held well beyond 500 cycles.
        step(1, 0, 1);
        repeat (650) step(1, 1, 0);

        // Lockout release with expired low.
        step(1, 0, 1);
        repeat (4) step(1, 0, 0);

        // ena gating: idle gating, then drop ena mid-warning.
        repeat (100) step(0, 1, 0);
        repeat (2) step(1, 1, 0);
        repeat (4) step(0, 1, 0);
        step(1, 0, 0);

        // Trigger, then assert rst_n between edges three cycles into RESET.
        guard = 0;
        step(1, 1, 0);
        while (!(m_busy && m_t == W + 3) && guard < 50) begin
            step(1, 1, 0);
            guard++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), {3'd0, 1'b0, 1'b1, 1'b0, 4'd0});
        model_reset();
        watchdog_expired = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomised bursts of held expiry levels.
        for (int b = 0; b < 80; b++) begin
            bit x;
            int len;
            x   = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                step(($urandom_range(0, 15) != 0), x, ($urandom_range(0, 63) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
